// File: rtl/msu_sd_pkg.sv
// Shared types and constants for the MSU SD sector server.
package msu_sd_pkg;

  localparam int unsigned LBA_W        = 21;
  localparam int unsigned SECTOR_WORDS = 256;
  localparam int unsigned SECTOR_BYTES = 512;
  localparam int unsigned WORD_IDX_W   = 8;
  localparam int unsigned MEM_AW       = LBA_W + WORD_IDX_W;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StFetch,
    StWrite,
    StGap,
    StDone
  } state_e;

  // ceil(size/512)-1 without widening past 32 bits; wraps to all-ones for size 0.
  function automatic logic [31:0] last_sector(input logic [31:0] size);
    return (size >> 9) + 32'(size[8:0] != 9'd0) - 32'd1;
  endfunction

endpackage

// File: rtl/msu_sd_tail_mask.sv
// Decides whether a sector word, and its upper byte, lie inside the mounted image.
module msu_sd_tail_mask
  import msu_sd_pkg::*;
(
  input  logic [LBA_W-1:0]      i_lba,
  input  logic [WORD_IDX_W-1:0] i_w,
  input  logic [31:0]           i_size,
  input  logic                  i_oob,
  output logic                  o_word_valid,
  output logic                  o_hi_byte_valid
);

  logic [32:0] w_byte_lo;
  logic [32:0] w_byte_hi;
  logic [32:0] w_size;

  assign w_byte_lo = {3'b000, i_lba, i_w, 1'b0};
  assign w_byte_hi = {3'b000, i_lba, i_w, 1'b1};
  assign w_size    = {1'b0, i_size};

  assign o_word_valid    = !i_oob && (w_byte_lo < w_size);
  assign o_hi_byte_valid = o_word_valid && (w_byte_hi < w_size);

endmodule

// File: rtl/msu_sd_sector_server.sv
// Serves sd_rd sector requests from a word-wide image store, clipped to the image size.
module msu_sd_sector_server
  import msu_sd_pkg::*;
#(
  parameter int unsigned ACK_DELAY    = 4,
  parameter int unsigned WORD_GAP     = 0,
  parameter int unsigned SECTOR_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_sd_rd,
  input  logic [LBA_W-1:0]      i_sd_lba,
  input  logic [31:0]           i_img_size,
  input  logic                  i_img_mounted,
  output logic                  o_sd_ack,
  output logic                  o_sd_buff_wr,
  output logic [WORD_IDX_W-1:0] o_sd_buff_addr,
  output logic [15:0]           o_sd_buff_dout,
  output logic                  o_mem_req,
  output logic [MEM_AW-1:0]     o_mem_addr,
  input  logic                  i_mem_ack,
  input  logic [15:0]           i_mem_rdata,
  output logic                  o_err_oob,
  output logic                  o_busy,
  output logic [15:0]           o_sectors_served
);

  state_e                r_state;
  state_e                w_state_d;
  logic [LBA_W-1:0]      r_lba;
  logic [31:0]           r_size;
  logic                  r_oob;
  logic [WORD_IDX_W-1:0] r_w;
  logic [15:0]           r_cnt;
  logic [15:0]           r_data;
  logic                  r_err;
  logic [15:0]           r_served;

  logic w_word_valid;
  logic w_hi_valid;
  logic w_oob_in;
  logic w_last;

  assign w_oob_in = !i_img_mounted || (i_img_size == 32'd0) ||
                    ({11'd0, i_sd_lba} > last_sector(i_img_size));
  assign w_last   = (r_w == WORD_IDX_W'(SECTOR_WORDS - 1));

  msu_sd_tail_mask u_tail_mask (
    .i_lba           (r_lba),
    .i_w             (r_w),
    .i_size          (r_size),
    .i_oob           (r_oob),
    .o_word_valid    (w_word_valid),
    .o_hi_byte_valid (w_hi_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (i_sd_rd) w_state_d = (ACK_DELAY == 0) ? StFetch : StWait;
      StWait:  if (r_cnt <= 16'd1) w_state_d = StFetch;
      StFetch: if (!w_word_valid || i_mem_ack) w_state_d = StWrite;
      StWrite: begin
        if (WORD_GAP != 0) w_state_d = StGap;
        else               w_state_d = w_last ? StDone : StFetch;
      end
      StGap:   if (r_cnt <= 16'd1) w_state_d = w_last ? StDone : StFetch;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lba    <= '0;
      r_size   <= '0;
      r_oob    <= 1'b0;
      r_w      <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
      r_served <= '0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_sd_rd) begin
            r_lba  <= i_sd_lba;
            r_size <= i_img_size;
            r_oob  <= w_oob_in;
            r_w    <= '0;
            r_cnt  <= 16'(ACK_DELAY);
            if (ACK_DELAY == 0) r_err <= w_oob_in;
          end
        end
        StWait: begin
          r_cnt <= r_cnt - 16'd1;
          // err_oob coincides with the first cycle of sd_ack
          if (r_cnt <= 16'd1) r_err <= r_oob;
        end
        StFetch: begin
          if (!w_word_valid) r_data <= '0;
          else if (i_mem_ack) r_data <= {w_hi_valid ? i_mem_rdata[15:8] : 8'h00, i_mem_rdata[7:0]};
        end
        StWrite: begin
          if (WORD_GAP != 0) r_cnt <= 16'(WORD_GAP);
          else               r_w   <= r_w + 1'b1;
        end
        StGap: begin
          r_cnt <= r_cnt - 16'd1;
          if (r_cnt <= 16'd1) r_w <= r_w + 1'b1;
        end
        StDone:  r_served <= r_served + 16'd1;
        default: ;
      endcase
    end
  end

  assign o_sd_ack         = (r_state == StFetch) || (r_state == StWrite) || (r_state == StGap);
  assign o_sd_buff_wr     = (r_state == StWrite);
  assign o_sd_buff_addr   = r_w;
  assign o_sd_buff_dout   = r_data;
  assign o_mem_req        = (r_state == StFetch) && w_word_valid;
  assign o_mem_addr       = {r_lba, r_w};
  assign o_err_oob        = r_err;
  assign o_busy           = (r_state != StIdle);
  assign o_sectors_served = r_served;

endmodule
